// File: rtl/spi_poly_frontend_mp.sv
// SPI command frontend: LSB-first frames into a shadow polygon bank, published on frame_sync.
// Optional status readback on miso_out when SPI_READBACK_EN is defined.
`timescale 1ns/1ps
module spi_poly_frontend_mp #(
  parameter int NUM_POLY = 4,
  parameter int X_W      = 7,
  parameter int Y_W      = 6,
  parameter int COLOR_W  = 6,
  parameter int DEPTH_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs_in,
  input  logic                        sck_in,
  input  logic                        mosi_in,
  output logic                        miso_out,
  input  logic                        en_load,
  input  logic                        frame_sync,
  output logic [COLOR_W-1:0]          bg_color_out,
  output logic [NUM_POLY*COLOR_W-1:0] poly_color_out,
  output logic [NUM_POLY*X_W-1:0]     v0_x_out,
  output logic [NUM_POLY*X_W-1:0]     v1_x_out,
  output logic [NUM_POLY*X_W-1:0]     v2_x_out,
  output logic [NUM_POLY*Y_W-1:0]     v0_y_out,
  output logic [NUM_POLY*Y_W-1:0]     v1_y_out,
  output logic [NUM_POLY*Y_W-1:0]     v2_y_out,
  output logic [NUM_POLY*DEPTH_W-1:0] poly_depth_out,
  output logic [NUM_POLY-1:0]         poly_enable_out,
  output logic                        en_screen_out,
  output logic                        cmd_done,
  output logic                        cmd_err
);
  localparam int P          = COLOR_W + 3*X_W + 3*Y_W + DEPTH_W;
  localparam int FRAME_BITS = 8 + 8*((P + 7) / 8);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int IDX_W      = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1;
  localparam logic [4:0] NUM_POLY_L = 5'(NUM_POLY);
  localparam int O_V0X = COLOR_W;
  localparam int O_V1X = O_V0X + X_W;
  localparam int O_V2X = O_V1X + X_W;
  localparam int O_V0Y = O_V2X + X_W;
  localparam int O_V1Y = O_V0Y + Y_W;
  localparam int O_V2Y = O_V1Y + Y_W;
  localparam int O_D   = O_V2Y + Y_W;

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC, DONE} state_t;

  logic cs_s1_q, cs_s2_q, sck_s1_q, sck_s2_q, sck_s3_q, mosi_s1_q, mosi_s2_q;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [P-1:0] shadow_q [NUM_POLY];
  logic [P-1:0] active_q [NUM_POLY];
  logic [NUM_POLY-1:0] sh_en_q, act_en_q;
  logic [COLOR_W-1:0] bg_q;
  logic en_screen_q, err_sticky_q, cmd_done_q, cmd_err_q;
  logic [5:0] commit_q;
  logic sck_rise, bit_acc, abort_err, bad, exec_done, err_now;
  logic do_wr, do_clr, do_on, do_off, do_bg, do_rd, idx_ok;
  logic [7:0] cmd;
  logic [3:0] idx;
  logic [IDX_W-1:0] slot;
  logic [P-1:0] payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      cs_s1_q   <= cs_in;
      cs_s2_q   <= cs_s1_q;
      sck_s1_q  <= sck_in;
      sck_s2_q  <= sck_s1_q;
      sck_s3_q  <= sck_s2_q;
      mosi_s1_q <= mosi_in;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  assign sck_rise = sck_s2_q & ~sck_s3_q;
  assign bit_acc  = sck_rise & (en_load | ~en_screen_q) & (state_q == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  // New bits enter at the top so the first bit received settles at frame bit 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    abort_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_s2_q) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(FRAME_BITS)) begin
          state_d = EXEC;
        end else if (cs_s2_q) begin
          state_d   = IDLE;
          abort_err = (cnt_q != '0);
        end else if (bit_acc) begin
          frame_d = {mosi_s2_q, frame_q[FRAME_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      EXEC:    state_d = DONE;
      DONE:    if (cs_s2_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd     = frame_q[7:0];
  assign idx     = cmd[3:0];
  assign slot    = idx[IDX_W-1:0];
  assign payload = frame_q[8 +: P];
  assign idx_ok  = ({1'b0, idx} < NUM_POLY_L);

  always_comb begin
    do_wr  = 1'b0;
    do_clr = 1'b0;
    do_on  = 1'b0;
    do_off = 1'b0;
    do_bg  = 1'b0;
    do_rd  = 1'b0;
    bad    = 1'b0;
    if (state_q == EXEC) begin
      if (cmd[7:4] == 4'h8) begin
        if (idx_ok) do_wr = 1'b1;
        else        bad   = 1'b1;
      end else if (cmd[7:4] == 4'h4) begin
        if (idx_ok) do_clr = 1'b1;
        else        bad    = 1'b1;
      end else begin
        case (cmd)
          8'h21:   do_on  = 1'b1;
          8'h20:   do_off = 1'b1;
          8'h01:   do_bg  = 1'b1;
          8'h02:   do_rd  = 1'b1;
          default: bad    = 1'b1;
        endcase
      end
    end
  end

  assign exec_done = (state_q == EXEC) & ~bad;
  assign err_now   = abort_err | bad;

  // Writes land on the EXEC edge, so a coincident frame_sync publishes the old shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_POLY; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      sh_en_q  <= '0;
      act_en_q <= '0;
    end else begin
      if (frame_sync) begin
        active_q <= shadow_q;
        act_en_q <= sh_en_q;
      end
      if (do_wr) begin
        shadow_q[slot] <= payload;
        sh_en_q[slot]  <= 1'b1;
      end
      if (do_clr) begin
        shadow_q[slot] <= '0;
        sh_en_q[slot]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bg_q         <= '0;
      en_screen_q  <= 1'b0;
      commit_q     <= '0;
      err_sticky_q <= 1'b0;
      cmd_done_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      cmd_done_q <= exec_done;
      cmd_err_q  <= err_now;
      if (do_bg)     bg_q        <= payload[COLOR_W-1:0];
      if (do_on)     en_screen_q <= 1'b1;
      if (do_off)    en_screen_q <= 1'b0;
      if (exec_done) commit_q    <= commit_q + 6'd1;
      if (err_now)    err_sticky_q <= 1'b1;
      else if (do_rd) err_sticky_q <= 1'b0;
    end
  end

`ifdef SPI_READBACK_EN
  logic rd_q, miso_q, sck_fall;
  logic [7:0] status;
  logic [CNT_W-1:0] rb_sel;
  assign sck_fall = ~sck_s2_q & sck_s3_q;
  assign status   = {commit_q, err_sticky_q, en_screen_q};
  assign rb_sel   = cnt_q - CNT_W'(8);

  // Status bit k follows the falling edge after rising edge 8+k of a 0x02 frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      if (state_q == IDLE)
        rd_q <= 1'b0;
      else if (bit_acc && cnt_q == CNT_W'(7))
        rd_q <= ({mosi_s2_q, frame_q[FRAME_BITS-1 -: 7]} == 8'h02);
      if (state_q != SHIFT)
        miso_q <= 1'b0;
      else if (sck_fall)
        miso_q <= rd_q && cnt_q >= CNT_W'(8) && cnt_q < CNT_W'(16) && status[rb_sel[2:0]];
    end
  end
  assign miso_out = miso_q;
`else
  assign miso_out = 1'b0;
`endif

  for (genvar i = 0; i < NUM_POLY; i++) begin : g_out
    assign poly_color_out[i*COLOR_W +: COLOR_W] = active_q[i][0 +: COLOR_W];
    assign v0_x_out[i*X_W +: X_W]               = active_q[i][O_V0X +: X_W];
    assign v1_x_out[i*X_W +: X_W]               = active_q[i][O_V1X +: X_W];
    assign v2_x_out[i*X_W +: X_W]               = active_q[i][O_V2X +: X_W];
    assign v0_y_out[i*Y_W +: Y_W]               = active_q[i][O_V0Y +: Y_W];
    assign v1_y_out[i*Y_W +: Y_W]               = active_q[i][O_V1Y +: Y_W];
    assign v2_y_out[i*Y_W +: Y_W]               = active_q[i][O_V2Y +: Y_W];
    assign poly_depth_out[i*DEPTH_W +: DEPTH_W] = active_q[i][O_D +: DEPTH_W];
  end

  assign poly_enable_out = act_en_q;
  assign bg_color_out    = bg_q;
  assign en_screen_out   = en_screen_q;
  assign cmd_done        = cmd_done_q;
  assign cmd_err         = cmd_err_q;
endmodule

// File: tb/tb_spi_poly_frontend_mp.sv
// Randomised bench for spi_poly_frontend_mp against a field-level model of the command set.
// Readback expectations follow SPI_READBACK_EN when that macro is defined.
`timescale 1ns/1ps
module tb_spi_poly_frontend_mp;
  localparam int NP = 4, XW = 7, YW = 6, CW = 6, DW = 3;
  localparam int P  = CW + 3*XW + 3*YW + DW;
  localparam int FB = 8 + 8*((P + 7) / 8);

  typedef struct {
    logic [CW-1:0] c;
    logic [XW-1:0] x0, x1, x2;
    logic [YW-1:0] y0, y1, y2;
    logic [DW-1:0] d;
  } poly_t;

  logic clk = 1'b0, rst = 1'b1;
  logic cs_in = 1'b1, sck_in = 1'b0, mosi_in = 1'b0, en_load = 1'b1, frame_sync = 1'b0;
  logic miso_out, en_screen_out, cmd_done, cmd_err;
  logic [CW-1:0] bg_color_out;
  logic [NP*CW-1:0] poly_color_out;
  logic [NP*XW-1:0] v0_x_out, v1_x_out, v2_x_out;
  logic [NP*YW-1:0] v0_y_out, v1_y_out, v2_y_out;
  logic [NP*DW-1:0] poly_depth_out;
  logic [NP-1:0] poly_enable_out;

  spi_poly_frontend_mp dut (
    .clk(clk), .rst(rst), .cs_in(cs_in), .sck_in(sck_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .en_load(en_load), .frame_sync(frame_sync),
    .bg_color_out(bg_color_out), .poly_color_out(poly_color_out),
    .v0_x_out(v0_x_out), .v1_x_out(v1_x_out), .v2_x_out(v2_x_out),
    .v0_y_out(v0_y_out), .v1_y_out(v1_y_out), .v2_y_out(v2_y_out),
    .poly_depth_out(poly_depth_out), .poly_enable_out(poly_enable_out),
    .en_screen_out(en_screen_out), .cmd_done(cmd_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int done_seen = 0, err_seen = 0;
  logic [7:0] rb_cap;

  always @(negedge clk) begin
    if (cmd_done === 1'b1) done_seen++;
    if (cmd_err === 1'b1) err_seen++;
  end

  // Reference model state
  poly_t sh[NP], act[NP];
  bit sh_en[NP], act_en[NP];
  logic [CW-1:0] m_bg;
  bit m_scr, m_sticky;
  int m_commit;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic poly_t zero_poly();
    poly_t z;
    z.c = '0; z.x0 = '0; z.x1 = '0; z.x2 = '0;
    z.y0 = '0; z.y1 = '0; z.y2 = '0; z.d = '0;
    return z;
  endfunction

  function automatic poly_t rand_poly();
    poly_t p;
    p.c  = CW'($urandom); p.x0 = XW'($urandom); p.x1 = XW'($urandom); p.x2 = XW'($urandom);
    p.y0 = YW'($urandom); p.y1 = YW'($urandom); p.y2 = YW'($urandom); p.d = DW'($urandom);
    return p;
  endfunction

  function automatic logic [FB-1:0] build(input logic [7:0] cmd, input poly_t p);
    logic [FB-1:0] f;
    int o;
    f = '0;
    f[7:0] = cmd;
    o = 8;
    f[o +: CW] = p.c;  o += CW;
    f[o +: XW] = p.x0; o += XW;
    f[o +: XW] = p.x1; o += XW;
    f[o +: XW] = p.x2; o += XW;
    f[o +: YW] = p.y0; o += YW;
    f[o +: YW] = p.y1; o += YW;
    f[o +: YW] = p.y2; o += YW;
    f[o +: DW] = p.d;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      sh[i] = zero_poly(); act[i] = zero_poly(); sh_en[i] = 0; act_en[i] = 0;
    end
    m_bg = '0; m_scr = 0; m_sticky = 0; m_commit = 0;
  endtask

  task automatic model_fs();
    for (int i = 0; i < NP; i++) begin
      act[i] = sh[i];
      act_en[i] = sh_en[i];
    end
  endtask

  task automatic model_frame(input logic [7:0] cmd, input poly_t p, input int nbits,
                             output int ed, output int ee, output logic [7:0] erb);
    int acc, idx;
    ed = 0; ee = 0; erb = 8'h00;
    acc = (m_scr && !en_load) ? 0 : nbits;
    if (acc < FB) begin
      if (acc > 0) begin ee = 1; m_sticky = 1; end
      return;
    end
    idx = int'(cmd[3:0]);
    if (cmd[7:4] == 4'h8 && idx < NP) begin
      sh[idx] = p; sh_en[idx] = 1; ed = 1;
    end else if (cmd[7:4] == 4'h4 && idx < NP) begin
      sh[idx] = zero_poly(); sh_en[idx] = 0; ed = 1;
    end else if (cmd == 8'h21) begin
      m_scr = 1; ed = 1;
    end else if (cmd == 8'h20) begin
      m_scr = 0; ed = 1;
    end else if (cmd == 8'h01) begin
      m_bg = p.c; ed = 1;
    end else if (cmd == 8'h02) begin
`ifdef SPI_READBACK_EN
      erb = {6'(m_commit), m_sticky, m_scr};
`endif
      m_sticky = 0; ed = 1;
    end else begin
      ee = 1; m_sticky = 1;
    end
    if (ed != 0) m_commit = (m_commit + 1) % 64;
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < NP; i++) begin
      check_val($sformatf("%s.s%0d.color", tag, i), poly_color_out[i*CW +: CW], act[i].c);
      check_val($sformatf("%s.s%0d.v0x", tag, i), v0_x_out[i*XW +: XW], act[i].x0);
      check_val($sformatf("%s.s%0d.v1x", tag, i), v1_x_out[i*XW +: XW], act[i].x1);
      check_val($sformatf("%s.s%0d.v2x", tag, i), v2_x_out[i*XW +: XW], act[i].x2);
      check_val($sformatf("%s.s%0d.v0y", tag, i), v0_y_out[i*YW +: YW], act[i].y0);
      check_val($sformatf("%s.s%0d.v1y", tag, i), v1_y_out[i*YW +: YW], act[i].y1);
      check_val($sformatf("%s.s%0d.v2y", tag, i), v2_y_out[i*YW +: YW], act[i].y2);
      check_val($sformatf("%s.s%0d.depth", tag, i), poly_depth_out[i*DW +: DW], act[i].d);
      check_val($sformatf("%s.s%0d.en", tag, i), poly_enable_out[i], act_en[i]);
    end
    check_val({tag, ".bg"}, bg_color_out, m_bg);
    check_val({tag, ".screen"}, en_screen_out, m_scr);
  endtask

  task automatic shift_bits(input logic [FB-1:0] f, input int nbits, input bit fs_at_exec);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi_in = f[i];
      repeat (3) @(negedge clk);
      if (i >= 8 && i < 16) rb_cap[3'(i - 8)] = miso_out;
      sck_in = 1'b1;
      if (fs_at_exec && i == nbits - 1) begin
        // two sync flops, edge detect, accept, then the EXEC cycle
        repeat (4) @(posedge clk);
        @(negedge clk); frame_sync = 1'b1;
        @(negedge clk); frame_sync = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
      end
      sck_in = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic fs_pulse();
    @(negedge clk); frame_sync = 1'b1;
    @(negedge clk); frame_sync = 1'b0;
    model_fs();
  endtask

  task automatic do_frame(input string tag, input logic [7:0] cmd, input poly_t p,
                          input int nbits, input int extra, input bit fs_at_exec);
    int d0, e0, ed, ee;
    logic [7:0] erb;
    d0 = done_seen; e0 = err_seen; rb_cap = 8'h00;
    @(negedge clk); cs_in = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(build(cmd, p), nbits, fs_at_exec);
    for (int k = 0; k < extra; k++) begin
      @(negedge clk); sck_in = 1'b1; mosi_in = 1'($urandom);
      repeat (3) @(negedge clk); sck_in = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk); cs_in = 1'b1;
    repeat (8) @(negedge clk);
    if (fs_at_exec) model_fs();
    model_frame(cmd, p, nbits, ed, ee, erb);
    check_val({tag, ".done"}, 64'(done_seen - d0), 64'(ed));
    check_val({tag, ".err"}, 64'(err_seen - e0), 64'(ee));
    if (cmd == 8'h02 && nbits == FB) check_val({tag, ".miso"}, rb_cap, erb);
    compare_all(tag);
  endtask

  initial begin
    poly_t p, q;
    int op, sel;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset");
    check_val("reset.miso", miso_out, 1'b0);
    check_val("reset.done", cmd_done, 1'b0);
    check_val("reset.err", cmd_err, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    p.c = 6'h2A; p.x0 = 7'd5; p.y0 = 6'd3; p.x1 = 7'd100; p.y1 = 6'd60;
    p.x2 = 7'd127; p.y2 = 6'd63; p.d = 3'd5;
    do_frame("wr2", 8'h82, p, FB, 0, 0);
    fs_pulse();
    compare_all("wr2_fs");
    check_val("wr2_fs.enables", poly_enable_out, 4'b0100);

    q = zero_poly();
    do_frame("scr_on", 8'h21, q, FB, 0, 0);
    q.c = 6'h15;
    en_load = 1'b0;
    do_frame("bg_blocked", 8'h01, q, FB, 0, 0);
    en_load = 1'b1;
    do_frame("bg_load", 8'h01, q, FB, 0, 0);
    check_val("bg_load.value", bg_color_out, 6'h15);

    do_frame("scr_off", 8'h20, q, FB, 0, 0);
    do_frame("abort20", 8'h83, rand_poly(), 20, 0, 0);
    do_frame("scr_on2", 8'h21, q, FB, 0, 0);

    do_frame("bad_idx", 8'h85, rand_poly(), FB, 0, 0);
    do_frame("extra_sck", 8'h83, rand_poly(), FB, 10, 0);

    do_frame("coincide", 8'h82, rand_poly(), FB, 0, 1);
    fs_pulse();
    compare_all("coincide_next");

    @(negedge clk); cs_in = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(build(8'h81, rand_poly()), 20, 0);
    #3 rst = 1'b1;
    #1 model_reset();
    compare_all("rst_mid");
    check_val("rst_mid.miso", miso_out, 1'b0);
    @(negedge clk); cs_in = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    compare_all("rst_after");

    do_frame("rb_w", 8'h81, rand_poly(), FB, 0, 0);
    do_frame("rb_bg", 8'h01, rand_poly(), FB, 0, 0);
    do_frame("rb_off", 8'h20, rand_poly(), FB, 0, 0);
    do_frame("rb_bad", 8'h85, rand_poly(), FB, 0, 0);
    do_frame("rb_read1", 8'h02, rand_poly(), FB, 0, 0);
    do_frame("rb_read2", 8'h02, rand_poly(), FB, 0, 0);

    for (int it = 0; it < 36; it++) begin
      en_load = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 9);
      sel = $urandom_range(0, 5);
      case (op)
        0, 1, 2: do_frame($sformatf("rnd%0d.wr", it), 8'h80 | 8'(sel), rand_poly(), FB, 0, $urandom_range(0, 3) == 0);
        3:       do_frame($sformatf("rnd%0d.clr", it), 8'h40 | 8'(sel), rand_poly(), FB, 0, 0);
        4:       do_frame($sformatf("rnd%0d.bg", it), 8'h01, rand_poly(), FB, 0, 0);
        5:       do_frame($sformatf("rnd%0d.scr", it), sel[0] ? 8'h21 : 8'h20, rand_poly(), FB, 0, 0);
        6:       begin fs_pulse(); compare_all($sformatf("rnd%0d.fs", it)); end
        7:       do_frame($sformatf("rnd%0d.abort", it), 8'h83, rand_poly(), $urandom_range(1, FB - 1), 0, 0);
        8:       do_frame($sformatf("rnd%0d.read", it), 8'h02, rand_poly(), FB, 0, 0);
        default: do_frame($sformatf("rnd%0d.cmd", it), 8'($urandom), rand_poly(), FB, 0, 0);
      endcase
    end
    fs_pulse();
    compare_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
